wb_select_pipe: RTL and testbench

Parametrised, registered writeback-select stage for the nRisc datapath, replacing the combinational 2:1 memory/ALU result mux. Selects one of NSRC WIDTH-bit result sources, tags it with the destination register, and delivers it through a 2-entry skid buffer with valid/ready handshakes on both sides. Sits between execute/memory and the register-file write port, so a stalled register file no longer backs up combinationally into the ALU.

---
 rtl/wb_select_pipe_if.sv | 28 ++
 rtl/wb_select_pipe.sv | 85 ++++++++
 tb/tb_wb_select_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wb_select_pipe_if.sv
// wb_select_pipe_if: source-select inputs, result output and status bundle for wb_select_pipe
interface wb_select_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 2,
  parameter int SELW  = 1,
  parameter int TAGW  = 3,
  parameter int CNTW  = 16
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       sel;
  logic [TAGW-1:0]       in_tag;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [TAGW-1:0]       out_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNTW-1:0]       xfer_count;
  logic                  sel_err;
  modport slave (
    input  src_data, sel, in_tag, in_valid, out_ready,
    output in_ready, out_data, out_tag, out_valid, xfer_count, sel_err
  );
  modport master (
    output src_data, sel, in_tag, in_valid, out_ready,
    input  in_ready, out_data, out_tag, out_valid, xfer_count, sel_err
  );
endinterface

// File: rtl/wb_select_pipe.sv
// wb_select_pipe: registered writeback source select with 2-entry skid buffer; WB_SELECT_CHECK_EN enables sticky sel_err
module wb_select_pipe #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 2,
  parameter int SELW  = 1,
  parameter int TAGW  = 3,
  parameter int CNTW  = 16
) (
  input logic              clk,
  input logic              rst,
  wb_select_pipe_if.slave  bus
);
  logic [WIDTH-1:0] data_q, data_d, skid_data_q, skid_data_d, sel_data;
  logic [TAGW-1:0]  tag_q, tag_d, skid_tag_q, skid_tag_d;
  logic             valid_q, valid_d, skid_valid_q, skid_valid_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]  sel;
  logic             sel_ok, acc, dlv;
  assign sel      = bus.sel;
  assign sel_ok   = 32'(sel) < NSRC;
  assign sel_data = sel_ok ? bus.src_data[sel*WIDTH +: WIDTH] : '0;
  assign acc      = bus.in_valid & ~skid_valid_q;
  assign dlv      = valid_q & bus.out_ready;
  assign bus.in_ready   = ~skid_valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_valid  = valid_q;
  assign bus.xfer_count = cnt_q;
  // next state: skid refills main first, otherwise a new word lands in main if it frees up, else in skid
  always_comb begin
    data_d       = data_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = acc ? cnt_q + CNTW'(1) : cnt_q;
    if (dlv && skid_valid_q) begin
      data_d       = skid_data_q;
      tag_d        = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (acc && (!valid_q || dlv)) begin
      data_d  = sel_data;
      tag_d   = bus.in_tag;
      valid_d = 1'b1;
    end else if (acc) begin
      skid_data_d  = sel_data;
      skid_tag_d   = bus.in_tag;
      skid_valid_d = 1'b1;
    end else if (dlv) begin
      valid_d = 1'b0;
    end
  end
  // state registers; reset drops any held words immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      data_q       <= data_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end
`ifdef WB_SELECT_CHECK_EN
  logic err_q;
  // sticky flag for any accepted out-of-range select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (acc && !sel_ok) err_q <= 1'b1;
  end
  assign bus.sel_err = err_q;
`else
  assign bus.sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_select_pipe.sv
// tb_wb_select_pipe: scoreboard bench for wb_select_pipe (default and NSRC=3/CNTW=4 instances)
module tb_wb_select_pipe;
`ifdef WB_SELECT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  wb_select_pipe_if #(.WIDTH(8), .NSRC(2), .SELW(1), .TAGW(3), .CNTW(16)) b0 ();
  wb_select_pipe_if #(.WIDTH(8), .NSRC(3), .SELW(2), .TAGW(3), .CNTW(4))  b1 ();
  wb_select_pipe #(.WIDTH(8), .NSRC(2), .SELW(1), .TAGW(3), .CNTW(16)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  wb_select_pipe #(.WIDTH(8), .NSRC(3), .SELW(2), .TAGW(3), .CNTW(4))  d1 (.clk(clk), .rst(rst), .bus(b1.slave));
  typedef struct packed {logic [7:0] d; logic [2:0] t;} item_t;
  item_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;
  int          delivered = 0;
  function automatic logic [7:0] pick(input logic [31:0] src, input int s, input int nsrc);
    return (s < nsrc) ? 8'((src >> (8 * s)) & 32'hff) : 8'h00;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] src, input logic s, input logic [2:0] t);
    bit done = 0;
    b0.src_data = src;
    b0.sel      = s;
    b0.in_tag   = t;
    b0.in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = b0.in_ready;
      tick();
    end
    b0.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask
  initial begin
    int c0, dv0;
    bit bad;
    logic [23:0] s1;
    logic [1:0]  sl;
    b0.src_data = '0; b0.sel = '0; b0.in_tag = '0; b0.in_valid = 1'b0; b0.out_ready = 1'b0;
    b1.src_data = '0; b1.sel = '0; b1.in_tag = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          exp_cnt = 0;
        end else begin
          chk("xfer_count", 32'(b0.xfer_count), 32'(exp_cnt[15:0]));
          chk("out_valid", 32'(b0.out_valid), 32'(q.size() > 0));
          chk("in_ready", 32'(b0.in_ready), 32'(q.size() < 2));
          chk("sel_err0", 32'(b0.sel_err), 0);
          if (b0.out_valid && q.size() > 0) begin
            chk("out_data", 32'(b0.out_data), 32'(q[0].d));
            chk("out_tag", 32'(b0.out_tag), 32'(q[0].t));
            if (b0.out_ready) begin
              void'(q.pop_front());
              delivered++;
            end
          end
          if (b0.in_valid && b0.in_ready) begin
            q.push_back('{d: pick(32'(b0.src_data), int'(b0.sel), 2), t: b0.in_tag});
            exp_cnt++;
          end
        end
      end
    join_none
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(b0.out_valid), 0);
    chk("rst_out_data", 32'(b0.out_data), 0);
    chk("rst_out_tag", 32'(b0.out_tag), 0);
    chk("rst_in_ready", 32'(b0.in_ready), 1);
    chk("rst_xfer_count", 32'(b0.xfer_count), 0);
    chk("rst_sel_err", 32'(b1.sel_err), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    b0.out_ready = 1'b1;
    b0.src_data = 16'h0D11; b0.sel = 1'b0; b0.in_tag = 3'd3; b0.in_valid = 1'b1;
    tick();
    chk("lat_valid", 32'(b0.out_valid), 1);
    chk("lat_data0", 32'(b0.out_data), 32'h11);
    chk("lat_tag0", 32'(b0.out_tag), 3);
    b0.sel = 1'b1; b0.in_tag = 3'd5;
    tick();
    chk("lat_data1", 32'(b0.out_data), 32'h0D);
    chk("lat_tag1", 32'(b0.out_tag), 5);
    b0.in_valid = 1'b0;
    tick();
    c0 = int'(b0.xfer_count);
    dv0 = delivered;
    for (int i = 0; i < 10; i++) begin
      b0.src_data = 16'($urandom); b0.sel = 1'($urandom); b0.in_tag = 3'(i); b0.in_valid = 1'b1;
      tick();
    end
    b0.in_valid = 1'b0;
    tick();
    tick();
    chk("b2b_count", 32'(int'(b0.xfer_count) - c0), 10);
    chk("b2b_delivered", 32'(delivered - dv0), 10);
    b0.out_ready = 1'b0;
    c0 = int'(b0.xfer_count);
    send(16'h00A1, 1'b0, 3'd1);
    send(16'hB200, 1'b1, 3'd2);
    b0.src_data = 16'h00C3; b0.sel = 1'b0; b0.in_tag = 3'd4; b0.in_valid = 1'b1;
    tick(); tick(); tick();
    chk("stall_in_ready", 32'(b0.in_ready), 0);
    chk("stall_main", 32'(b0.out_data), 32'hA1);
    chk("stall_count", 32'(int'(b0.xfer_count) - c0), 2);
    b0.out_ready = 1'b1;
    for (int i = 0; i < 10 && int'(b0.xfer_count) - c0 < 3; i++) tick();
    b0.in_valid = 1'b0;
    chk("stall_c_taken", 32'(int'(b0.xfer_count) - c0), 3);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_drained", 32'(b0.out_valid), 0);
    b0.out_ready = 1'b0;
    send(16'h0055, 1'b0, 3'd6);
    send(16'h6600, 1'b1, 3'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(b0.out_valid), 0);
    chk("arst_in_ready", 32'(b0.in_ready), 1);
    chk("arst_count", 32'(b0.xfer_count), 0);
    tick();
    rst = 1'b0;
    tick();
    b0.out_ready = 1'b1;
    send(16'h7700, 1'b1, 3'd2);
    chk("post_rst_data", 32'(b0.out_data), 32'h77);
    tick();
    bad = 1'b0;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s1 = 24'($urandom);
      sl = 2'(i % 4);
      b1.src_data = s1; b1.sel = sl; b1.in_tag = 3'(i);
      tick();
      if (sl == 2'd3) bad = 1'b1;
      chk("n3_data", 32'(b1.out_data), 32'(pick(32'(s1), int'(sl), 3)));
      chk("n3_tag", 32'(b1.out_tag), 32'(i % 8));
      chk("n3_sel_err", 32'(b1.sel_err), 32'(CHK & bad));
    end
    b1.in_valid = 1'b0;
    tick();
    chk("n3_wrap", 32'(b1.xfer_count), 1);
    chk("n3_sel_err_hold", 32'(b1.sel_err), 32'(CHK));
    for (int i = 0; i < 400; i++) begin
      b0.src_data = 16'($urandom); b0.sel = 1'($urandom); b0.in_tag = 3'($urandom);
      b0.in_valid = ($urandom_range(9) < 7);
      b0.out_ready = ($urandom_range(9) < 6);
      tick();
    end
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("final_empty", 32'(b0.out_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
